// File: rtl/sar_pkg.sv
// Shared constants for the successive-approximation search controller:
// FSM state encoding and the default operand width.
package sar_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1
    } sar_state_t;

endpackage

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial values onto a
// magnitude comparator's B operand and resolves the unknown A operand MSB-first.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             A_gt_B,
    input  logic             A_lt_B,
    input  logic             A_eq_B,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] TRIAL_MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IW-1:0]    IDX_TOP   = IW'(WIDTH - 1);

    sar_state_t       state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [WIDTH-1:0] trial_n, result_n;
    logic             busy_n, done_n, hit_n, err_n;

    logic [2:0]       flags;
    logic             flags_onehot;
    logic [WIDTH-1:0] resolved;
    logic [WIDTH-1:0] next_trial;

    assign flags        = {A_gt_B, A_lt_B, A_eq_B};
    assign flags_onehot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= IDX_TOP;
            trial  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hit    <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            trial  <= trial_n;
            result <= result_n;
            busy   <= busy_n;
            done   <= done_n;
            hit    <= hit_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        trial_n  = trial;
        result_n = result;
        busy_n   = busy;
        hit_n    = hit;
        done_n   = 1'b0;
        err_n    = 1'b0;

        // Bit under test is kept when A is above the trial, dropped when below;
        // the next lower bit then becomes the new tentative one.
        resolved      = trial;
        resolved[idx] = A_gt_B;
        next_trial    = resolved;
        next_trial[idx - IW'(1)] = 1'b1;

        case (state)
            IDLE: begin
                trial_n = '0;
                busy_n  = 1'b0;
                if (start) begin
                    trial_n = TRIAL_MSB;
                    idx_n   = IDX_TOP;
                    busy_n  = 1'b1;
                    hit_n   = 1'b0;
                    state_n = SEARCH;
                end
            end

            SEARCH: begin
                if (!flags_onehot) begin
                    err_n    = 1'b1;
                    result_n = '0;
                    hit_n    = 1'b0;
                    busy_n   = 1'b0;
                    trial_n  = '0;
                    state_n  = IDLE;
                end else if (A_eq_B) begin
                    result_n = trial;
                    hit_n    = 1'b1;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    trial_n  = '0;
                    state_n  = IDLE;
                end else if (idx == '0) begin
                    result_n = resolved;
                    hit_n    = 1'b0;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    trial_n  = '0;
                    state_n  = IDLE;
                end else begin
                    trial_n = next_trial;
                    idx_n   = idx - IW'(1);
                end
            end

            default: begin
                trial_n = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller; the driving end of the 4-bit magnitude comparator interface.
- Drives a trial value onto the comparator's B operand and reads back A_gt_B / A_lt_B / A_eq_B.
- Resolves the unknown A operand MSB-first in at most WIDTH compare cycles.
- Used standalone in the lab datapath and as a self-checking consumer of the existing 4-bit comparator.

Parameters:
- WIDTH, 4, operand width in bits (trial, result, bit index range); must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a new search; sampled only in IDLE
- A_gt_B  input  1  comparator flag: A > trial
- A_lt_B  input  1  comparator flag: A < trial
- A_eq_B  input  1  comparator flag: A == trial
- trial  output  WIDTH  value driven to comparator B operand
- busy  output  1  high while in SEARCH
- done  output  1  one-cycle pulse, result valid
- hit  output  1  valid with done; 1 if terminated by A_eq_B, 0 if resolved by exhausting all bits
- err  output  1  one-cycle pulse on an illegal flag combination
- result  output  WIDTH  resolved A value; held until the next accepted start

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high. All outputs are registered.
- Reset values: state=IDLE, trial=0, busy=0, done=0, hit=0, err=0, result=0, bit index=WIDTH-1.
- The comparator is combinational. Flags are sampled at the edge that ends each SEARCH cycle and refer to the trial presented during that cycle.
- IDLE:
  - trial=0, busy=0.
  - On start=1 at edge k: trial<=1 followed by WIDTH-1 zeros, idx<=WIDTH-1, busy<=1, go to SEARCH. The hit register is cleared at the same edge.
- SEARCH, per edge, evaluated in priority order:
  1. Flags not exactly one-hot (000, 011, 101, 110, 111): err<=1 (one cycle), result<=0, hit<=0, done stays 0, busy<=0, trial<=0, go to IDLE.
  2. A_eq_B: result<=trial, hit<=1, done<=1, busy<=0, trial<=0, go to IDLE.
  3. Otherwise compute nxt = trial with bit idx kept if A_gt_B, cleared if A_lt_B.
     - If idx==0: result<=nxt, hit<=0, done<=1, go to IDLE.
     - Else: trial<=nxt with bit idx-1 set, idx<=idx-1.
- Latency: done rises after edge k+n, where n is the number of compare cycles (1..WIDTH). Worst case is WIDTH.
- Pulses: done and err are single-cycle. They are never asserted together, and never while busy=1.
- start while busy is ignored. start during the done cycle is accepted (state is already IDLE).
- rst mid-search aborts immediately to reset values. No done or err is produced for the aborted search.
- result changes only on done, on err, or on reset.

Decomposition:
- Shared package (sar_pkg): state encoding constants IDLE=2'd0, SEARCH=2'd1, and the DEFAULT_WIDTH=4 constant.
- No sub-module inside the block: one state register, an idx counter and the trial/result registers.
- The bench instantiates the existing 4-bit comparator with WIDTH=4, A driven by the bench and B driven from trial.

Test Plan:
- A=4'b1011, pulse start: trial sequence 1000 → 1100 → 1010 → 1011. done at edge k+4 with result=1011, hit=1.
- A=4'b1000: first trial matches. done at edge k+1 with result=1000, hit=1, busy high for exactly 1 cycle.
- A=4'b0000: trials 1000 → 0100 → 0010 → 0001, all A_lt_B. done at k+4 with result=0000, hit=0.
- A=4'b0111: trials 1000 → 0100 → 0110 → 0111 (eq). result=0111, hit=1. Re-assert start during busy at cycle k+2: ignored, no extra done.
- Bench forces flags to 000 on the second SEARCH cycle: err pulses once at k+2, result=0, done never asserts, back in IDLE with trial=0.
- A=4'b1111, assert rst at cycle k+2: at the next edge all outputs are at reset values, no done. A new start then yields result=1111 after 4 cycles.
